// File: rtl/axilite_regslave.sv
// rtl/axilite_regslave.sv - AXI4-Lite responder exposing NREG 32-bit registers driven out flat.
// Optional build macro AXILITE_REGSLAVE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axilite_regslave #(
  parameter int          ADDRW    = 13,
  parameter int          NREG     = 16,
  parameter logic [31:0] REG_INIT = 32'h0000_0000,
  localparam int         IDXW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ADDRW-1:0]     awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [ADDRW-1:0]     araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [NREG*32-1:0]   regs_flat,
  output logic                 wr_strobe,
  output logic [IDXW-1:0]      wr_idx
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXILITE_REGSLAVE_SLVERR_EN
  localparam logic [1:0] RESP_ERR  = 2'b10;
`else
  localparam logic [1:0] RESP_ERR  = 2'b00;
`endif

  logic              alive;
  logic              aw_full;
  logic              w_full;
  logic [ADDRW-3:0]  aw_word;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [31:0]       regs [NREG];

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic              wr_ok;
  logic              rd_ok;
  logic [IDXW-1:0]   aw_idx;
  logic [IDXW-1:0]   ar_idx;
  logic              unused_addr_bits;

  function automatic logic word_in_range(input logic [ADDRW-3:0] word);
    return 32'(word) < 32'(NREG);
  endfunction

  // Byte offsets carry no meaning for whole-word registers.
  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  assign awready = alive & ~aw_full;
  assign wready  = alive & ~w_full;
  assign arready = alive & (~rvalid | rready);

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign ar_hs  = arvalid & arready;
  assign commit = aw_full & w_full & ~bvalid;

  assign wr_ok  = word_in_range(aw_word);
  assign rd_ok  = word_in_range(araddr[ADDRW-1:2]);
  assign aw_idx = aw_word[IDXW-1:0];
  assign ar_idx = araddr[2 +: IDXW];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) alive <= 1'b0;
    else      alive <= 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      aw_full <= 1'b0;
      aw_word <= '0;
    end else if (aw_hs) begin
      aw_full <= 1'b1;
      aw_word <= awaddr[ADDRW-1:2];
    end else if (commit) begin
      aw_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      w_full <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (w_hs) begin
      w_full <= 1'b1;
      w_data <= wdata;
      w_strb <= wstrb;
    end else if (commit) begin
      w_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (commit) begin
      bvalid <= 1'b1;
      bresp  <= wr_ok ? RESP_OKAY : RESP_ERR;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_strobe <= 1'b0;
      wr_idx    <= '0;
    end else begin
      wr_strobe <= commit & wr_ok;
      if (commit && wr_ok) wr_idx <= aw_idx;
    end
  end

  // wstrb of zero still counts as a committed write; it just touches no lane.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < NREG; k++) regs[k] <= REG_INIT;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Reads sample the flops before this edge's commit lands, so a colliding read sees the old value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_ok ? regs[ar_idx] : 32'h0;
      rresp  <= rd_ok ? RESP_OKAY : RESP_ERR;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign regs_flat[32*k +: 32] = regs[k];
  end

endmodule

// File: tb/tb_axilite_regslave.sv
// tb/tb_axilite_regslave.sv - directed plus randomized bench for axilite_regslave against a register-array model.
module tb_axilite_regslave;

  localparam logic [31:0] RINIT = 32'h1234_5678;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [12:0]  awaddr, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid, wr_strobe;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [511:0] regs_flat;
  logic [3:0]   wr_idx;

  int checks = 0;
  int errors = 0;
  logic [31:0] mreg [16];

  axilite_regslave #(.ADDRW(13), .NREG(16), .REG_INIT(RINIT)) dut (
    .CLK(clk), .RST(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_idx(wr_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_reg(input int k);
    return regs_flat[32*k +: 32];
  endfunction

  function automatic logic in_rng(input logic [12:0] a);
    return a[12:2] < 11'd16;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [12:0] a);
    return in_rng(a) ? mreg[a[5:2]] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [12:0] a);
`ifdef AXILITE_REGSLAVE_SLVERR_EN
    return in_rng(a) ? 2'b00 : 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  task automatic model_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (in_rng(a)) mreg[a[5:2]] = (mreg[a[5:2]] & ~mask) | (d & mask);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) mreg[k] = RINIT;
  endtask

  task automatic chk_all_regs(input string tag);
    for (int k = 0; k < 16; k++) chk($sformatf("%s_reg%0d", tag, k), dut_reg(k), mreg[k]);
  endtask

  // Starts and ends at a falling edge; bready is held high so the B handshake completes.
  task automatic do_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    logic ha, hw;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      ha = awvalid & awready;
      hw = wvalid & wready;
      @(negedge clk); n++;
      if (ha) awvalid = 1'b0;
      if (hw) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk); n++;
    end
    chk("wr_bvalid", bvalid, 1);
    chk("wr_bresp", bresp, exp_resp(a));
    chk("wr_strobe", wr_strobe, in_rng(a));
    if (in_rng(a)) chk("wr_idx", wr_idx, a[5:2]);
    model_write(a, d, s);
    @(negedge clk);
    bready = 1'b0;
    chk("wr_bdone", bvalid, 0);
  endtask

  task automatic do_read(input logic [12:0] a);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 20) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_rvalid", rvalid, 1);
    chk($sformatf("rd_data_%h", a), rdata, exp_rd(a));
    chk("rd_rresp", rresp, exp_resp(a));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rd_done", rvalid, 0);
  endtask

  initial begin
    logic [12:0] a, aq [$];
    logic [31:0] v1, v2, d;

    rst_n = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    model_reset();

    // Reset state and release timing
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk_all_regs("rst");
    rst_n = 1'b1;
    #1;
    chk("cyc0_awready", awready, 0);
    chk("cyc0_arready", arready, 0);
    @(negedge clk);
    chk("cyc1_awready", awready, 1);
    chk("cyc1_wready", wready, 1);
    chk("cyc1_arready", arready, 1);
    do_read(13'h004);

    // AW and W in the same cycle
    awaddr = 13'h008; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 1;
    chk("sim_awready", awready, 1);
    chk("sim_wready", wready, 1);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("sim_b_early", bvalid, 0);
    @(negedge clk);
    chk("sim_bvalid", bvalid, 1);
    chk("sim_bresp", bresp, 0);
    chk("sim_strobe", wr_strobe, 1);
    chk("sim_wr_idx", wr_idx, 2);
    model_write(13'h008, 32'hDEADBEEF, 4'hF);
    chk("sim_reg2", dut_reg(2), 32'hDEADBEEF);
    @(negedge clk);
    bready = 0;
    chk("sim_bdone", bvalid, 0);
    chk("sim_strobe_off", wr_strobe, 0);
    do_read(13'h008);

    // W three cycles before AW, partial strobes
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    chk("wfirst_wready", wready, 0);
    chk("wfirst_awready", awready, 1);
    repeat (2) begin
      @(negedge clk);
      chk("wfirst_nob", bvalid, 0);
    end
    awaddr = 13'h008; awvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0;
    chk("wfirst_b_early", bvalid, 0);
    @(negedge clk);
    chk("wfirst_bvalid", bvalid, 1);
    model_write(13'h008, 32'h11223344, 4'b0101);
    chk("wfirst_reg2", dut_reg(2), 32'hDE22BE44);
    @(negedge clk);
    bready = 0;

    // B back-pressure with a second write buffered behind it
    awaddr = 13'h014; wdata = 32'hCAFE0001; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("bp_bvalid", bvalid, 1);
    model_write(13'h014, 32'hCAFE0001, 4'hF);
    awaddr = 13'h018; wdata = 32'hBEEF0002; awvalid = 1; wvalid = 1;
    chk("bp_aw2_ready", awready, 1);
    chk("bp_w2_ready", wready, 1);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    repeat (5) begin
      chk("bp_hold_bvalid", bvalid, 1);
      chk("bp_hold_bresp", bresp, 0);
      chk("bp_stall_aw", awready, 0);
      chk("bp_stall_w", wready, 0);
      chk("bp_reg6_unchanged", dut_reg(6), mreg[6]);
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    chk("bp_b1_done", bvalid, 0);
    @(negedge clk);
    chk("bp_b2_valid", bvalid, 1);
    chk("bp_b2_strobe", wr_strobe, 1);
    chk("bp_b2_idx", wr_idx, 6);
    model_write(13'h018, 32'hBEEF0002, 4'hF);
    chk("bp_reg6", dut_reg(6), mreg[6]);
    @(negedge clk);
    bready = 0;
    chk("bp_b2_done", bvalid, 0);

    // Out-of-range and boundary accesses
    do_write(13'h040, $urandom, 4'hF);
    chk_all_regs("oor");
    do_read(13'h1FFC);
    do_write(13'h03C, 32'h0F0F_A5A5, 4'hF);
    do_read(13'h03C);
    do_write(13'h03C, 32'hFFFF_FFFF, 4'h0);
    do_read(13'h03F);

    // Read collides with commit to the same register
    v1 = $urandom; v2 = ~v1;
    do_write(13'h00C, v1, 4'hF);
    awaddr = 13'h00C; wdata = v2; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    araddr = 13'h00C; arvalid = 1;
    chk("col_arready", arready, 1);
    @(negedge clk);
    arvalid = 0;
    chk("col_rvalid", rvalid, 1);
    chk("col_old_value", rdata, v1);
    chk("col_bvalid", bvalid, 1);
    model_write(13'h00C, v2, 4'hF);
    rready = 1;
    @(negedge clk);
    rready = 0; bready = 0;
    do_read(13'h00C);

    // Randomized writes with random byte offsets and strobes
    for (int i = 0; i < 24; i++) begin
      a = {$urandom_range(0, 19), 2'($urandom_range(0, 3))};
      do_write(a, $urandom, 4'($urandom));
    end
    chk_all_regs("rand");

    // Back-to-back reads, one per cycle
    rready = 1;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom_range(0, 17), 2'($urandom_range(0, 3))};
      araddr = a; arvalid = 1;
      chk("b2b_arready", arready, 1);
      if (i > 0) begin
        chk("b2b_rvalid", rvalid, 1);
        chk("b2b_rdata", rdata, exp_rd(aq[0]));
        chk("b2b_rresp", rresp, exp_resp(aq[0]));
        void'(aq.pop_front());
      end
      aq.push_back(a);
      @(negedge clk);
    end
    arvalid = 0;
    chk("b2b_last_rvalid", rvalid, 1);
    chk("b2b_last_rdata", rdata, exp_rd(aq[0]));
    @(negedge clk);
    rready = 0;
    chk("b2b_done", rvalid, 0);

    // Reset with a B response pending
    awaddr = 13'h01C; wdata = 32'h5555AAAA; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("rstb_pending", bvalid, 1);
    rst_n = 0;
    #1;
    chk("rstb_bvalid", bvalid, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    chk_all_regs("rstb");
    @(negedge clk);
    chk("rstb_bvalid2", bvalid, 0);

    // A buffered AW is discarded by reset, so a later lone W must not commit
    awaddr = 13'h020; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    d = $urandom;
    wdata = d; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rsta_no_commit", bvalid, 0);
      chk("rsta_no_strobe", wr_strobe, 0);
      chk("rsta_reg8", dut_reg(8), RINIT);
    end
    awaddr = 13'h020; awvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0;
    @(negedge clk);
    chk("rsta_late_bvalid", bvalid, 1);
    model_write(13'h020, d, 4'hF);
    chk("rsta_reg8_new", dut_reg(8), mreg[8]);
    @(negedge clk);
    bready = 0;
    chk_all_regs("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
